dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Parametrised, handshaked data memory for the pipelined core's MEM stage.
- Successor of the single-cycle word RAM: configurable data width (32/64), depth and read latency.
- Adds a valid/ready request/response protocol, byte-enable stores, misalignment and illegal-op reporting, and a one-outstanding-transaction state machine.

Parameters:
- DATA_WIDTH, 32, data word width; legal values 32 or 64 (64 enables ld/sd/lwu).
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 64, number of DATA_WIDTH words; power of two.
- RD_LATENCY, 1, cycles from request acceptance to load response; legal values 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V load/store funct3.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and faults.
- rsp_fault  out  1  request was not performed.
- rsp_cause  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 out of range.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - req_ready=0 while rst_n is low, then 1 from the first clk after release.
  - rsp_valid=0, rsp_rdata=0, rsp_fault=0, rsp_cause=00.
  - Memory contents are not reset; they are zero-initialised for simulation only.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture the request; go to WAIT if the request is a legal load and RD_LATENCY>1, otherwise go to RESP.
  - WAIT: a counter loaded with RD_LATENCY-1 counts down to 1, then the FSM goes to RESP.
  - RESP: rsp_valid=1. Outputs are held stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE; req_ready rises on the next cycle (no same-cycle re-accept).
- Timing:
  - Stores write the array at the accepting clock edge.
  - Stores and faulted requests respond 1 cycle after acceptance.
  - Legal loads respond exactly RD_LATENCY cycles after acceptance.
- Word index = addr[ADDR_WIDTH-1:OFF] mod DEPTH, where OFF = log2(DATA_WIDTH/8).
- Legal funct3:
  - Both widths: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
  - DATA_WIDTH=64 only: 011 ld/sd, 110 lwu.
  - Store funct3 must be 000..010, or 011 at width 64.
  - Anything else is cause 10.
- Misaligned (cause 01): half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0. No array write, rdata 0.
- Cause priority: illegal > misaligned > out of range.
- Stores: byte-enable write. Only the addressed lanes change; other bytes are preserved.
- Loads:
  - lb/lh/lw are sign-extended to DATA_WIDTH; lbu/lhu/lwu are zero-extended.
  - At 64-bit width, lw sign-extends bit 31.
- Load data is sampled at acceptance. A store issued after a load cannot affect that load's response, because only one transaction is outstanding.
- Reset mid-transaction: the transaction is abandoned, the response is never delivered, and a store already committed stays committed.

Optional Feature:
- Macro: DMEM_OOB_FAULT_EN.
- Defined: a word index >= DEPTH (upper address bits non-zero) faults with cause 11. No write, rdata 0.
- Undefined: the address wraps mod DEPTH silently, and cause 11 is never produced.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - cause codes (CAUSE_OK, CAUSE_MISALIGN, CAUSE_ILLEGAL, CAUSE_OOB);
  - the state enum (IDLE, WAIT, RESP).
- One sub-module, dmem_lane_align (combinational), produces:
  - store byte-enables and shifted write data from addr/funct3/wdata;
  - the extracted and extended load result from the word, addr and funct3.
- The top level owns the FSM, latency counter, array and response registers.

Test Plan:
- sw 0xDEADBEEF @0x10, then lb @0x13 / lbu @0x13 / lh @0x12 / lhu @0x12 -> 0xFFFFFFDE / 0x000000DE / 0xFFFFDEAD / 0x0000DEAD; each has rsp_fault=0.
- sb 0x55 @0x11 over 0xDEADBEEF, then lw @0x10 -> 0xDEAD55EF (other bytes preserved).
- RD_LATENCY=3, lw accepted at cycle T -> rsp_valid at T+3. With rsp_ready held low 4 cycles: rsp_rdata stable, req_ready=0 throughout.
- lh @0x21 -> fault, cause 01, rdata 0. sw @0x22 -> cause 01, and the word @0x20 is unchanged. funct3=011 at width 32 -> cause 10.
- DEPTH=64, sw 0x12345678 @0x100 -> without the macro, lw @0x0 returns 0x12345678; with DMEM_OOB_FAULT_EN, cause 11 and @0x0 is unchanged.
- rst_n pulsed low while in WAIT -> rsp_valid never asserts, req_ready=1 one clk after release. DATA_WIDTH=64: sd 0x80000000_00000001, then lwu @+0 = 0x1 and lw @+4 = 0xFFFFFFFF80000000.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3, cause and state definitions shared by the dmem_lsu slice
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] CAUSE_OK       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_OOB      = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // size_log2 is funct3[1:0]: 0 byte, 1 half, 2 word, 3 double
    function automatic logic misaligned(input logic [1:0] size_log2, input logic [2:0] addr_lo);
        case (size_log2)
            2'b01:   return addr_lo[0];
            2'b10:   return |addr_lo[1:0];
            2'b11:   return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response bundle between the MEM stage and dmem_lsu
interface dmem_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_fault;
    logic [1:0]            rsp_cause;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_cause
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_cause
    );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and extraction/extension for loads
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFF        = $clog2(DATA_WIDTH / 8)
) (
    input  logic [OFF-1:0]          byte_off,
    input  logic [2:0]              funct3,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH-1:0]   rword,
    output logic [DATA_WIDTH/8-1:0] wbe,
    output logic [DATA_WIDTH-1:0]   wdata_sh,
    output logic [DATA_WIDTH-1:0]   rdata_ext
);
    localparam int NB = DATA_WIDTH / 8;

    logic [OFF+2:0]        bit_off;
    logic [DATA_WIDTH-1:0] rshift;

    assign bit_off  = {byte_off, 3'b000};
    assign wdata_sh = wdata << bit_off;
    assign rshift   = rword >> bit_off;

    // enable the 2^size lanes starting at the byte offset
    always_comb begin
        wbe = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i >= int'(byte_off)) && (i < int'(byte_off) + (1 << funct3[1:0]))) begin
                wbe[i] = 1'b1;
            end
        end
    end

    // pick the low bytes of the shifted word and sign- or zero-extend them
    always_comb begin
        rdata_ext = rshift;
        case (funct3)
            F3_B:    rdata_ext = DATA_WIDTH'($signed(rshift[7:0]));
            F3_H:    rdata_ext = DATA_WIDTH'($signed(rshift[15:0]));
            F3_W:    rdata_ext = DATA_WIDTH'($signed(rshift[31:0]));
            F3_BU:   rdata_ext = DATA_WIDTH'(rshift[7:0]);
            F3_HU:   rdata_ext = DATA_WIDTH'(rshift[15:0]);
            F3_WU:   rdata_ext = DATA_WIDTH'(rshift[31:0]);
            default: rdata_ext = rshift;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - handshaked data memory for the MEM stage; DMEM_OOB_FAULT_EN enables out-of-range faults
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int RD_LATENCY = 1
) (
    input logic       clk,
    input logic       rst_n,
    dmem_lsu_if.slave bus
);
    localparam int         NB        = DATA_WIDTH / 8;
    localparam int         OFF       = $clog2(NB);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [2:0] WAIT_LOAD = 3'(RD_LATENCY - 1);

    state_t                state;
    logic [2:0]            wait_cnt;
    logic [DATA_WIDTH-1:0] pend_rdata;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_fault_q;
    logic [1:0]            rsp_cause_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic [IDX_W-1:0]      idx;
    logic                  illegal;
    logic                  misalign;
    logic                  oob;
    logic                  fault;
    logic [1:0]            cause;
    logic [NB-1:0]         wbe;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] rdata_ext;

    assign accept   = bus.req_valid && req_ready_q;
    assign idx      = bus.req_addr[OFF +: IDX_W];
    assign misalign = misaligned(bus.req_funct3[1:0], bus.req_addr[2:0]);

`ifdef DMEM_OOB_FAULT_EN
    assign oob = |bus.req_addr[ADDR_WIDTH-1:OFF+IDX_W];
`else
    // upper address bits are ignored: the index wraps modulo DEPTH
    logic unused_addr_hi;
    assign unused_addr_hi = |bus.req_addr[ADDR_WIDTH-1:OFF+IDX_W];
    assign oob            = 1'b0;
`endif

    assign fault = illegal || misalign || oob;

    // funct3 legality depends on direction and on whether doublewords exist
    always_comb begin
        illegal = 1'b0;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = bus.req_we;
            F3_D:             illegal = (DATA_WIDTH != 64);
            F3_WU:            illegal = bus.req_we || (DATA_WIDTH != 64);
            default:          illegal = 1'b1;
        endcase
    end

    // highest-priority fault wins the cause code
    always_comb begin
        cause = CAUSE_OK;
        if (illegal) begin
            cause = CAUSE_ILLEGAL;
        end else if (misalign) begin
            cause = CAUSE_MISALIGN;
        end else if (oob) begin
            cause = CAUSE_OOB;
        end
    end

    dmem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFF        (OFF)
    ) u_align (
        .byte_off  (bus.req_addr[OFF-1:0]),
        .funct3    (bus.req_funct3),
        .wdata     (bus.req_wdata),
        .rword     (mem[idx]),
        .wbe       (wbe),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    // byte-enabled store commits on the accepting edge; contents are never reset
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !fault) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // one-outstanding FSM: load data is captured at acceptance, delayed in WAIT, held in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            pend_rdata  <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
            rsp_cause_q <= CAUSE_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        if (!bus.req_we && !fault && (RD_LATENCY > 1)) begin
                            state      <= WAIT;
                            wait_cnt   <= WAIT_LOAD;
                            pend_rdata <= rdata_ext;
                        end else begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= (bus.req_we || fault) ? '0 : rdata_ext;
                            rsp_fault_q <= fault;
                            rsp_cause_q <= cause;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd1) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pend_rdata;
                        rsp_fault_q <= 1'b0;
                        rsp_cause_q <= CAUSE_OK;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_fault_q <= 1'b0;
                        rsp_cause_q <= CAUSE_OK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_cause = rsp_cause_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized bench for dmem_lsu against a byte-addressed reference model
module tb_dmem_lsu;
    import dmem_pkg::*;

    localparam int DW        = 64;
    localparam int AW        = 32;
    localparam int DEPTH     = 64;
    localparam int LAT       = 3;
    localparam int MEM_BYTES = DEPTH * DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_lsu #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RD_LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference memory as a flat little-endian byte array
    bit [7:0] mb [MEM_BYTES];

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
        logic [1:0]  cause;
        int          lat;
        longint      acc;
    } exp_t;

    exp_t   q[$];
    longint edge_n    = 0;
    int     since_rst = 0;

    function automatic exp_t model_access(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr, input logic [63:0] wd);
        exp_t        e;
        int          nb;
        int          base;
        bit          legal;
        logic [63:0] v;
        nb      = 1 << f3[1:0];
        legal   = we ? (f3 <= 3'd3) : (f3 != 3'd7);
        e.rdata = '0;
        e.fault = 1'b1;
        e.lat   = 1;
        e.acc   = 0;
        e.cause = 2'b00;
        if (!legal) begin
            e.cause = 2'b10;
        end else if ((addr % nb) != 0) begin
            e.cause = 2'b01;
`ifdef DMEM_OOB_FAULT_EN
        end else if (addr >= MEM_BYTES) begin
            e.cause = 2'b11;
`endif
        end else begin
            e.fault = 1'b0;
            base    = int'(addr % MEM_BYTES);
            if (we) begin
                for (int i = 0; i < nb; i++) mb[base+i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[base+i];
                if (!f3[2] && nb < 8 && v[8*nb-1]) begin
                    for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
                end
                e.rdata = v;
                e.lat   = LAT;
            end
        end
        return e;
    endfunction

    // acceptance and response handshakes drive the expectation queue
    always @(posedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.rsp_valid && bus.rsp_ready && q.size() > 0) void'(q.pop_front());
            if (bus.req_valid && bus.req_ready) begin
                e     = model_access(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata);
                e.acc = edge_n;
                q.push_back(e);
            end
            since_rst++;
        end
        edge_n++;
    end

    always @(negedge rst_n) begin
        q.delete();
        since_rst = 0;
    end

    // every cycle: outputs must match the model's view of the outstanding transaction
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_rsp_valid", bus.rsp_valid, 0);
            chk("reset_req_ready", bus.req_ready, 0);
            chk("reset_rsp_rdata", bus.rsp_rdata, 0);
            chk("reset_rsp_cause", {bus.rsp_fault, bus.rsp_cause}, 0);
        end else if (q.size() == 0) begin
            chk("idle_rsp_valid", bus.rsp_valid, 0);
            if (since_rst >= 1) chk("idle_req_ready", bus.req_ready, 1);
        end else begin
            chk("busy_req_ready", bus.req_ready, 0);
            chk("rsp_valid_timing", bus.rsp_valid, (edge_n - q[0].acc) >= q[0].lat);
            if (bus.rsp_valid) begin
                chk("rsp_rdata", bus.rsp_rdata, q[0].rdata);
                chk("rsp_fault", bus.rsp_fault, q[0].fault);
                chk("rsp_cause", bus.rsp_cause, q[0].cause);
            end
        end
    end

    // issue one request from a negedge, wait for the response, stall, then take it
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] wd, input int stall,
                          output logic [63:0] rd, output logic flt, output logic [1:0] cs,
                          output int lat);
        int t;
        rd  = '0;
        flt = 1'b0;
        cs  = 2'b00;
        lat = 0;
        t   = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL req_ready_timeout: req_ready=0, expected 1 within 20 cycles");
            return;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_valid_timeout: rsp_valid=0, expected 1 within 10 cycles");
            return;
        end
        repeat (stall) @(negedge clk);
        rd  = bus.rsp_rdata;
        flt = bus.rsp_fault;
        cs  = bus.rsp_cause;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic lit(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd, input int stall,
                       input logic [63:0] e_rd, input logic e_flt, input logic [1:0] e_cs,
                       input int e_lat);
        logic [63:0] rd;
        logic        flt;
        logic [1:0]  cs;
        int          lat;
        do_req(we, f3, addr, wd, stall, rd, flt, cs, lat);
        chk({name, "_rdata"}, rd, e_rd);
        chk({name, "_fault"}, flt, e_flt);
        chk({name, "_cause"}, cs, e_cs);
        chk({name, "_latency"}, lat, e_lat);
    endtask

    // request accepted, then reset before the response is taken
    task automatic reset_mid(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [63:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_low_before_clk", bus.req_ready, 0);
        @(negedge clk);
        chk("ready_one_clk_after_release", bus.req_ready, 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [63:0] rd;
        logic        flt;
        logic [1:0]  cs;
        int          lat;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;

        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_first_clk", bus.req_ready, 0);
        @(negedge clk);
        chk("ready_after_release", bus.req_ready, 1);

        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b1, F3_D, 32'(i * 8), {$urandom, $urandom}, 0, rd, flt, cs, lat);
        end

        lit("sw_beef",  1'b1, F3_W,  32'h10, 64'hDEADBEEF, 0, 64'h0, 1'b0, 2'b00, 1);
        lit("lb_13",    1'b0, F3_B,  32'h13, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFDE, 1'b0, 2'b00, LAT);
        lit("lbu_13",   1'b0, F3_BU, 32'h13, 64'h0, 0, 64'h0000_0000_0000_00DE, 1'b0, 2'b00, LAT);
        lit("lh_12",    1'b0, F3_H,  32'h12, 64'h0, 1, 64'hFFFF_FFFF_FFFF_DEAD, 1'b0, 2'b00, LAT);
        lit("lhu_12",   1'b0, F3_HU, 32'h12, 64'h0, 0, 64'h0000_0000_0000_DEAD, 1'b0, 2'b00, LAT);
        lit("sb_55",    1'b1, F3_B,  32'h11, 64'h55, 0, 64'h0, 1'b0, 2'b00, 1);
        lit("lw_stall", 1'b0, F3_W,  32'h10, 64'h0, 4, 64'hFFFF_FFFF_DEAD_55EF, 1'b0, 2'b00, LAT);
        lit("lwu_10",   1'b0, F3_WU, 32'h10, 64'h0, 0, 64'h0000_0000_DEAD_55EF, 1'b0, 2'b00, LAT);

        lit("sw_20",    1'b1, F3_W,  32'h20, 64'h11223344, 0, 64'h0, 1'b0, 2'b00, 1);
        lit("lh_mis",   1'b0, F3_H,  32'h21, 64'h0, 0, 64'h0, 1'b1, 2'b01, 1);
        lit("sw_mis",   1'b1, F3_W,  32'h22, 64'hAAAAAAAA, 2, 64'h0, 1'b1, 2'b01, 1);
        lit("lw_20",    1'b0, F3_W,  32'h20, 64'h0, 0, 64'h0000_0000_1122_3344, 1'b0, 2'b00, LAT);
        lit("f3_111",   1'b0, 3'b111, 32'h20, 64'h0, 0, 64'h0, 1'b1, 2'b10, 1);
        lit("ill_mis",  1'b0, 3'b111, 32'h21, 64'h0, 0, 64'h0, 1'b1, 2'b10, 1);
        lit("st_f3_4",  1'b1, F3_BU, 32'h20, 64'hFF, 0, 64'h0, 1'b1, 2'b10, 1);
        lit("st_f3_6",  1'b1, F3_WU, 32'h20, 64'hFF, 0, 64'h0, 1'b1, 2'b10, 1);

        lit("sw_0",     1'b1, F3_W,  32'h0, 64'hCAFEF00D, 0, 64'h0, 1'b0, 2'b00, 1);
`ifdef DMEM_OOB_FAULT_EN
        lit("sw_oob",   1'b1, F3_W,  32'h200, 64'h12345678, 0, 64'h0, 1'b1, 2'b11, 1);
        lit("lw_0",     1'b0, F3_W,  32'h0, 64'h0, 0, 64'hFFFF_FFFF_CAFE_F00D, 1'b0, 2'b00, LAT);
`else
        lit("sw_wrap",  1'b1, F3_W,  32'h200, 64'h12345678, 0, 64'h0, 1'b0, 2'b00, 1);
        lit("lw_0",     1'b0, F3_W,  32'h0, 64'h0, 0, 64'h0000_0000_1234_5678, 1'b0, 2'b00, LAT);
`endif

        lit("sd_40",    1'b1, F3_D,  32'h40, 64'h8000_0000_0000_0001, 0, 64'h0, 1'b0, 2'b00, 1);
        lit("lwu_40",   1'b0, F3_WU, 32'h40, 64'h0, 0, 64'h0000_0000_0000_0001, 1'b0, 2'b00, LAT);
        lit("lw_44",    1'b0, F3_W,  32'h44, 64'h0, 0, 64'hFFFF_FFFF_8000_0000, 1'b0, 2'b00, LAT);
        lit("ld_mis",   1'b0, F3_D,  32'h44, 64'h0, 0, 64'h0, 1'b1, 2'b01, 1);
        lit("sh_46",    1'b1, F3_H,  32'h46, 64'hBEEF, 0, 64'h0, 1'b0, 2'b00, 1);
        lit("ld_40",    1'b0, F3_D,  32'h40, 64'h0, 0, 64'hBEEF_0000_0000_0001, 1'b0, 2'b00, LAT);

        reset_mid(1'b0, F3_D, 32'h40, 64'h0);
        reset_mid(1'b1, F3_D, 32'h30, 64'h0123_4567_89AB_CDEF);
        lit("ld_after_rst", 1'b0, F3_D, 32'h30, 64'h0, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 2'b00, LAT);

        for (int n = 0; n < 500; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 2 * MEM_BYTES - 1));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            if ($urandom_range(0, 15) == 0) a[31:28] = 4'($urandom);
            do_req(we, f3, a, {$urandom, $urandom}, int'($urandom_range(0, 3)), rd, flt, cs, lat);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
